// File: rtl/i2c_raw_tx_if.sv
// ----------------------------------------------------------------------------
// i2c_raw_tx_if : bundle of command, byte-stream and bus-line signals of the
//                 write-only I2C bit generator.
//   slave  modport : the generator itself (i2c_raw_tx)
//   master modport : whatever issues commands, supplies bytes, and observes
//                    the SCL/SDA lines
// Signals:
//   i_start, i_addr[6:0]           command request and slave address
//   i_data[7:0], i_data_last,      byte stream, MSB first
//   i_data_valid, o_data_ready
//   i_sda_in                       sampled bus SDA level for ACK slots
//   o_scl, o_sda                   line levels (1 = released)
//   o_busy, o_done, o_nack         status
// ----------------------------------------------------------------------------
interface i2c_raw_tx_if;
   logic       i_start;
   logic [6:0] i_addr;
   logic [7:0] i_data;
   logic       i_data_last;
   logic       i_data_valid;
   logic       o_data_ready;
   logic       i_sda_in;
   logic       o_scl;
   logic       o_sda;
   logic       o_busy;
   logic       o_done;
   logic       o_nack;

   modport slave (
      input  i_start, i_addr, i_data, i_data_last, i_data_valid, i_sda_in,
      output o_data_ready, o_scl, o_sda, o_busy, o_done, o_nack
   );

   modport master (
      output i_start, i_addr, i_data, i_data_last, i_data_valid, i_sda_in,
      input  o_data_ready, o_scl, o_sda, o_busy, o_done, o_nack
   );
endinterface

// File: rtl/i2c_raw_tx.sv
// ----------------------------------------------------------------------------
// i2c_raw_tx : single-master, write-only I2C bit generator.
//   Emits START, 7-bit address + W, one or more data bytes each followed by an
//   ACK slot, then STOP. One SCL bit lasts 4*CLK_DIV clock cycles.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous, active-low reset
//   io_bus   i2c_raw_tx_if.slave (command, byte stream, SCL/SDA, status)
// Parameters:
//   CLK_DIV  clk cycles per SCL quarter-period (>= 1)
// Build option:
//   I2C_TX_NACK_ABORT_EN  when defined, a NACK in any ACK slot ends the
//                         transfer with STOP right after that ACK cell.
// ----------------------------------------------------------------------------
module i2c_raw_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   i2c_raw_tx_if.slave  io_bus
);

   localparam int unsigned    QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0]  QMAX = QW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_LOAD, S_DATA, S_DACK, S_STOP
   } state_t;

   state_t        r_state, w_next;
   logic [QW-1:0] r_qcnt;
   logic [1:0]    r_quarter;
   logic [2:0]    r_bitcnt;
   logic [7:0]    r_shift;
   logic          r_last;
   logic          r_nack;

   logic w_qend, w_timed, w_accept, w_take, w_abort;
   logic w_scl, w_sda, w_ready, w_done;

   assign w_qend   = (r_qcnt == QMAX);
   assign w_timed  = (r_state != S_IDLE) && (r_state != S_LOAD);
   assign w_accept = (r_state == S_IDLE) && io_bus.i_start;
   assign w_take   = (r_state == S_LOAD) && io_bus.i_data_valid;

`ifdef I2C_TX_NACK_ABORT_EN
   // r_nack is cleared on accept, so it reflects only slots of this transfer
   assign w_abort = r_nack;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_qcnt    <= '0;
         r_quarter <= '0;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_last    <= 1'b0;
         r_nack    <= 1'b0;
      end else begin
         // quarter timer restarts on every state change
         if (!w_timed || (w_next != r_state)) begin
            r_qcnt    <= '0;
            r_quarter <= '0;
         end else if (w_qend) begin
            r_qcnt    <= '0;
            r_quarter <= r_quarter + 2'd1;
         end else begin
            r_qcnt    <= r_qcnt + 1'b1;
         end

         if (w_accept) begin
            r_shift  <= {io_bus.i_addr, 1'b0};
            r_bitcnt <= '0;
            r_nack   <= 1'b0;
         end else if (w_take) begin
            r_shift  <= io_bus.i_data;
            r_last   <= io_bus.i_data_last;
         end else if ((r_state == S_ADDR || r_state == S_DATA) &&
                      w_qend && r_quarter == 2'd3) begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
         end

         // slave drives ACK while SCL is high; sample at the end of Q2
         if ((r_state == S_AACK || r_state == S_DACK) &&
             w_qend && r_quarter == 2'd2 && io_bus.i_sda_in)
            r_nack <= 1'b1;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_scl   = 1'b1;
      w_sda   = 1'b1;
      w_ready = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (io_bus.i_start) w_next = S_START;
         end
         S_START: begin
            w_scl = (r_quarter != 2'd2);
            w_sda = (r_quarter == 2'd0);
            if (w_qend && r_quarter == 2'd2) w_next = S_ADDR;
         end
         S_ADDR, S_DATA: begin
            w_scl = r_quarter[1];
            w_sda = r_shift[7];
            if (w_qend && r_quarter == 2'd3 && r_bitcnt == 3'd7)
               w_next = (r_state == S_ADDR) ? S_AACK : S_DACK;
         end
         S_AACK, S_DACK: begin
            w_scl = r_quarter[1];
            if (w_qend && r_quarter == 2'd3)
               w_next = (w_abort || (r_state == S_DACK && r_last)) ? S_STOP : S_LOAD;
         end
         S_LOAD: begin
            // SDA keeps the released level of the preceding ACK cell
            w_scl   = 1'b0;
            w_ready = 1'b1;
            if (io_bus.i_data_valid) w_next = S_DATA;
         end
         S_STOP: begin
            w_scl = (r_quarter != 2'd0);
            w_sda = (r_quarter == 2'd2);
            if (w_qend && r_quarter == 2'd2) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign io_bus.o_scl        = w_scl;
   assign io_bus.o_sda        = w_sda;
   assign io_bus.o_data_ready = w_ready;
   assign io_bus.o_done       = w_done;
   assign io_bus.o_busy       = (r_state != S_IDLE);
   assign io_bus.o_nack       = r_nack;

endmodule

// File: tb/tb_i2c_raw_tx.sv
// ----------------------------------------------------------------------------
// tb_i2c_raw_tx : self-checking bench for i2c_raw_tx (CLK_DIV = 2).
//   A bus monitor decodes START/STOP and the SDA level at every SCL rise; the
//   expected bit stream, NACK flag and done latency are computed per transfer
//   from the protocol rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_raw_tx;
   localparam int unsigned CD = 2;
`ifdef I2C_TX_NACK_ABORT_EN
   localparam bit ABORT = 1'b1;
`else
   localparam bit ABORT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   i2c_raw_tx_if bus();

   i2c_raw_tx #(.CLK_DIV(CD)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .io_bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- bus monitor ----------------
   bit         mon_scl_q = 1'b1;
   bit         mon_sda_q = 1'b1;
   int         rise_cnt  = 0;
   int         n_start   = 0;
   int         n_stop    = 0;
   bit         mon_bits[$];
   logic [7:0] nack_mask = '0;

   always @(negedge clk) begin
      if (mon_scl_q && bus.o_scl && mon_sda_q && !bus.o_sda) begin
         n_start++;
         mon_bits.delete();
         rise_cnt = 0;
      end
      if (mon_scl_q && bus.o_scl && !mon_sda_q && bus.o_sda) n_stop++;
      if (!mon_scl_q && bus.o_scl) begin
         mon_bits.push_back(bus.o_sda);
         rise_cnt++;
      end
      mon_scl_q = bus.o_scl;
      mon_sda_q = bus.o_sda;
   end

   // every 9th SCL rise after START is an ACK slot; the slave answers from nack_mask
   assign bus.i_sda_in = (rise_cnt > 0 && rise_cnt % 9 == 0) ?
                         nack_mask[3'((rise_cnt / 9) - 1)] : 1'b0;

   // ---------------- one transfer ----------------
   task automatic run_xfer(input string tag, input logic [6:0] a, input int n,
                           input logic [7:0] bytes [4], input int dly [4],
                           input logic [7:0] mask, input bit busy_poke,
                           output int done_cyc);
      bit exp_bits[$];
      bit exp_nack, aborted;
      int sent, sum_dly, exp_cyc, k, dly_left, cyc, scl_hi_stall, mism, st0, sp0;

      // reference: expected SDA at each SCL rise, NACK flag and latency
      for (int i = 6; i >= 0; i--) exp_bits.push_back(a[i]);
      exp_bits.push_back(1'b0);
      exp_bits.push_back(1'b1);
      exp_nack = mask[0];
      aborted  = ABORT && mask[0];
      sent = 0;
      sum_dly = 0;
      for (int b = 0; b < n && !aborted; b++) begin
         sum_dly += dly[b];
         for (int i = 7; i >= 0; i--) exp_bits.push_back(bytes[b][i]);
         exp_bits.push_back(1'b1);
         sent++;
         exp_nack = exp_nack | mask[b+1];
         aborted  = ABORT && mask[b+1];
      end
      exp_bits.push_back(1'b0);   // SCL rise inside STOP with SDA low
      exp_cyc = CD * (6 + 36 * (sent + 1)) + sent + sum_dly;

      nack_mask = mask;
      @(negedge clk);
      check({tag, "/idle"}, {27'd0, bus.o_busy, bus.o_data_ready, bus.o_scl, bus.o_sda, bus.o_done},
            32'b00110);
      st0 = n_start;
      sp0 = n_stop;
      bus.i_start      = 1'b1;
      bus.i_addr       = a;
      bus.i_data       = bytes[0];
      bus.i_data_last  = (n == 1);
      bus.i_data_valid = (dly[0] == 0);
      k = 0;
      dly_left = dly[0];
      cyc = 0;
      done_cyc = -1;
      scl_hi_stall = 0;
      @(negedge clk);
      check({tag, "/accept"}, {30'd0, bus.o_busy, bus.o_nack}, 32'b10);
      while (done_cyc < 0 && cyc < 20000) begin
         cyc++;
         if (busy_poke && cyc == 40) begin
            bus.i_start = 1'b1;
            bus.i_addr  = ~a;
         end else begin
            bus.i_start = 1'b0;
         end
         if (bus.o_done) done_cyc = cyc;
         if (bus.o_data_ready) begin
            if (dly_left > 0) begin
               bus.i_data_valid = 1'b0;
               dly_left--;
               if (bus.o_scl) scl_hi_stall++;
            end else begin
               bus.i_data_valid = 1'b1;
               bus.i_data       = (k < 4) ? bytes[k] : 8'h00;
               bus.i_data_last  = (k == n - 1);
               k++;
               dly_left = (k < 4) ? dly[k] : 0;
            end
         end else begin
            bus.i_data_valid = 1'($urandom_range(0, 1));
            bus.i_data       = 8'($urandom);
            bus.i_data_last  = 1'($urandom_range(0, 1));
         end
         if (done_cyc < 0) @(negedge clk);
      end
      bus.i_start = 1'b0;

      mism = 0;
      for (int i = 0; i < exp_bits.size() && i < mon_bits.size(); i++)
         if (mon_bits[i] != exp_bits[i]) mism++;
      check({tag, "/latency"},  done_cyc, exp_cyc);
      check({tag, "/nack"},     {31'd0, bus.o_nack}, {31'd0, exp_nack});
      check({tag, "/nbits"},    mon_bits.size(), exp_bits.size());
      check({tag, "/bits"},     mism, 0);
      check({tag, "/startstop"}, {n_start - st0, n_stop - sp0}, {32'd1, 32'd1});
      check({tag, "/bytes"},    k, sent);
      check({tag, "/stall_scl"}, scl_hi_stall, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   logic [7:0] bt [4];
   int         dl [4];
   int         dc, n;
   bit         seen_done;
   logic [7:0] m;

   initial begin
      bus.i_start = 1'b0;
      bus.i_addr = '0;
      bus.i_data = '0;
      bus.i_data_last = 1'b0;
      bus.i_data_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_state", {26'd0, bus.o_scl, bus.o_sda, bus.o_busy, bus.o_done, bus.o_nack, bus.o_data_ready},
            32'b110000);
      reset = 1'b1;

      // single write 0x50 / 0xA5
      bt = '{8'hA5, 8'h00, 8'h00, 8'h00};
      dl = '{0, 0, 0, 0};
      run_xfer("single", 7'h50, 1, bt, dl, 8'h00, 1'b0, dc);
      check("single/157", dc, 157);

      // two bytes, 10-cycle stall in the second LOAD, back to back
      bt = '{8'h00, 8'hFF, 8'h00, 8'h00};
      dl = '{0, 10, 0, 0};
      run_xfer("stall", 7'h2B, 2, bt, dl, 8'h00, 1'b0, dc);

      // NACK on the address slot
      bt = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
      dl = '{0, 0, 0, 0};
      run_xfer("addr_nack", 7'($urandom), 2, bt, dl, 8'h01, 1'b0, dc);

      // accepted in the cycle after done (nack must clear), start poked while busy
      bt = '{8'h3C, 8'hC3, 8'h00, 8'h00};
      run_xfer("poke", 7'h11, 2, bt, dl, 8'h00, 1'b1, dc);

      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) begin
            bt[i] = 8'($urandom);
            dl[i] = $urandom_range(0, 3);
         end
         m = 8'($urandom) & 8'($urandom) & 8'((1 << (n + 1)) - 1);
         run_xfer($sformatf("rnd%0d", t), 7'($urandom), n, bt, dl, m, 1'($urandom_range(0, 1)), dc);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      @(negedge clk);
      check("done_width", {30'd0, bus.o_done, bus.o_busy}, 32'b00);

      // reset in the middle of a data byte
      nack_mask = '0;
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_addr = 7'h3C;
      bus.i_data = 8'h81;
      bus.i_data_last = 1'b1;
      bus.i_data_valid = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (CD * 39 + 1 + CD * 8) @(negedge clk);
      check("pre_reset_busy", {31'd0, bus.o_busy}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      seen_done = bus.o_done;
      check("mid_reset", {28'd0, bus.o_scl, bus.o_sda, bus.o_busy, bus.o_data_ready}, 32'b1100);
      repeat (2) begin
         @(negedge clk);
         seen_done = seen_done | bus.o_done;
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         seen_done = seen_done | bus.o_done;
      end
      check("reset_no_done", {30'd0, seen_done, bus.o_busy}, 32'b00);

      bt = '{8'h5A, 8'h00, 8'h00, 8'h00};
      dl = '{0, 0, 0, 0};
      run_xfer("after_reset", 7'h7F, 1, bt, dl, 8'h00, 1'b0, dc);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
